imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader.sv | 94 +++++++++
 tb/tb_imem_boot_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a byte-streamed program into IMEM as little-endian words,
// validates it with an XOR checksum and holds the core until the load succeeds.
module imem_boot_loader #(
    parameter int DEPTH_WORDS = 8,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              err
);
    localparam int IW = ADDR_W - 2;
    typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERROR} state_t;
    state_t        state, next_state;
    logic [1:0]    byte_cnt;
    logic [IW-1:0] word_idx, last_idx;
    logic [7:0]    chk;
    logic [23:0]   asm_r;
    logic          xfer, hdr_bad, restart;
    assign xfer    = in_valid && in_ready;
    assign hdr_bad = in_data == 8'd0 || in_data > 8'(DEPTH_WORDS);
    assign restart = start && (state == IDLE || state == DONE || state == ERROR);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: next_state = start ? HDR : state;
            HDR:  if (xfer) next_state = hdr_bad ? ERROR : DATA;
            DATA: if (xfer && byte_cnt == 2'd3 && word_idx == last_idx) next_state = CHK;
            CHK:  if (xfer) next_state = (in_data == chk) ? DONE : ERROR;
            default: next_state = IDLE;
        endcase
    end
    always_comb in_ready = state == HDR || state == DATA || state == CHK;
    // Bytes shift in from the top so the first three sit in little-endian order
    // when the fourth arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            last_idx  <= '0;
            chk       <= '0;
            asm_r     <= '0;
        end else begin
            wr_en <= 1'b0;
            if (restart) begin
                done      <= 1'b0;
                err       <= 1'b0;
                chk       <= '0;
                byte_cnt  <= '0;
                word_idx  <= '0;
                core_hold <= 1'b1;
            end else if (xfer) begin
                if (state != CHK) chk <= chk ^ in_data;
                if (state == HDR) begin
                    last_idx <= IW'(in_data - 8'd1);
                    err      <= hdr_bad;
                end
                if (state == DATA) begin
                    asm_r    <= {in_data, asm_r[23:8]};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= {word_idx, 2'b00};
                        wr_data  <= {in_data, asm_r};
                        word_idx <= word_idx + 1'b1;
                    end
                end
                if (state == CHK) begin
                    done      <= in_data == chk;
                    err       <= in_data != chk;
                    core_hold <= in_data != chk;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed streams checked every cycle against a byte-list model
// of the loader, plus literal expectations for the written words and final flags.
module tb_imem_boot_loader;
    logic        clk, reset, start, in_valid, in_ready, wr_en, core_hold, done, err;
    logic [7:0]  in_data;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    int checks = 0, failures = 0, cyc = 0;
    logic [7:0]  stim[$];
    int          la[$], lc[$];
    logic [31:0] ld[$];

    imem_boot_loader #(.DEPTH_WORDS(8), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_hold(core_hold), .done(done), .err(err));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the list of bytes accepted since start decides every output.
    logic        m_active, m_wr_en, m_done, m_err, m_hold;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [7:0]  mb[$];
    logic [7:0]  mx;
    int          mk, mn;
    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_wr_en = 0; m_done = 0; m_err = 0; m_hold = 1;
            m_addr = 0; m_data = 0; mb.delete();
        end else begin
            m_wr_en = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_done = 0; m_err = 0; m_hold = 1; mb.delete();
                end
            end else if (in_valid) begin
                mb.push_back(in_data);
                mk = mb.size();
                mn = int'(mb[0]);
                if (mk == 1) begin
                    if (mn == 0 || mn > 8) begin
                        m_active = 0; m_err = 1;
                    end
                end else if (mk <= 1 + 4 * mn) begin
                    if ((mk - 1) % 4 == 0) begin
                        m_wr_en = 1;
                        m_addr = 5'(((mk - 1) / 4 - 1) * 4);
                        m_data = {mb[mk-1], mb[mk-2], mb[mk-3], mb[mk-4]};
                    end
                end else begin
                    mx = 0;
                    for (int i = 0; i < mk - 1; i++) mx ^= mb[i];
                    m_active = 0;
                    if (in_data == mx) begin
                        m_done = 1; m_hold = 0;
                    end else m_err = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        check("in_ready", in_ready, m_active);
        check("wr_en", wr_en, m_wr_en);
        check("wr_addr", wr_addr, m_addr);
        check("wr_data", wr_data, m_data);
        check("done", done, m_done);
        check("err", err, m_err);
        check("core_hold", core_hold, m_hold);
        if (wr_en) begin
            la.push_back(int'(wr_addr)); ld.push_back(wr_data); lc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        in_valid = 1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for byte %h", b);
        end else @(negedge clk);
    endtask

    task automatic stream(input int gap);
        foreach (stim[i]) begin
            send(stim[i]);
            if (gap > 0) idle(gap);
        end
        in_valid = 0;
    endtask

    task automatic add_chk(input logic bad);
        logic [7:0] x = 0;
        foreach (stim[i]) x ^= stim[i];
        stim.push_back(bad ? x ^ 8'hFF : x);
    endtask

    task automatic clear_log();
        la.delete(); ld.delete(); lc.delete();
    endtask

    initial begin
        reset = 1; start = 0; in_valid = 0; in_data = 0;
        repeat (3) @(negedge clk);
        check("rst_hold", core_hold, 1);
        check("rst_ready", in_ready, 0);
        check("rst_done", done, 0);
        reset = 0;
        @(negedge clk);

        // single word, checksum 01^13^05^50^00 = 47
        pulse_start();
        stim = '{8'h01, 8'h13, 8'h05, 8'h50, 8'h00, 8'h47};
        stream(0);
        idle(3);
        check("t1_nwr", la.size(), 1);
        check("t1_addr", la[0], 0);
        check("t1_data", ld[0], 32'h00500513);
        check("t1_done", done, 1);
        check("t1_hold", core_hold, 0);
        check("t1_err", err, 0);

        // two words with in_valid toggling
        clear_log();
        pulse_start();
        stim = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_chk(0);
        stream(1);
        idle(3);
        check("t2_nwr", la.size(), 2);
        check("t2_a1", la[1], 4);
        check("t2_d0", ld[0], 32'h12345678);
        check("t2_d1", ld[1], 32'hDEADBEEF);
        check("t2_done", done, 1);

        // bad headers
        foreach (stim[i]) stim[i] = 0;
        for (int h = 0; h < 2; h++) begin
            clear_log();
            pulse_start();
            stim = '{(h == 0) ? 8'h00 : 8'h09};
            stream(0);
            idle(3);
            check("hdr_err", err, 1);
            check("hdr_hold", core_hold, 1);
            check("hdr_ready", in_ready, 0);
            check("hdr_nwr", la.size(), 0);
        end

        // bad checksum, then restart
        clear_log();
        pulse_start();
        stim = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        add_chk(1);
        stream(0);
        idle(3);
        check("t4_nwr", la.size(), 1);
        check("t4_data", ld[0], 32'h44332211);
        check("t4_err", err, 1);
        check("t4_done", done, 0);
        check("t4_hold", core_hold, 1);
        pulse_start();
        check("t4_restart_err", err, 0);
        check("t4_restart_ready", in_ready, 1);

        // reset after the second data byte
        clear_log();
        stim = '{8'h01, 8'hAA, 8'hBB};
        stream(0);
        reset = 1;
        #1;
        check("t5_ready", in_ready, 0);
        check("t5_wr_en", wr_en, 0);
        check("t5_hold", core_hold, 1);
        check("t5_addr", wr_addr, 0);
        check("t5_data", wr_data, 0);
        check("t5_err", err, 0);
        @(negedge clk);
        reset = 0;
        idle(2);
        check("t5_nwr", la.size(), 0);
        pulse_start();
        stim = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        add_chk(0);
        stream(0);
        idle(3);
        check("t5_done", done, 1);
        check("t5_d1", ld[1], 32'h08070605);

        // full depth back-to-back, start pulsed mid-DATA
        clear_log();
        pulse_start();
        stim = '{8'h08};
        for (int i = 0; i < 32; i++) stim.push_back(8'(i * 7 + 3));
        add_chk(0);
        fork
            stream(0);
            begin
                repeat (10) @(negedge clk);
                start = 1;
                @(negedge clk);
                start = 0;
            end
        join
        idle(3);
        check("t6_nwr", la.size(), 8);
        check("t6_last_addr", la[7], 28);
        check("t6_d0", ld[0], 32'h18110A03);
        check("t6_done", done, 1);
        for (int i = 1; i < lc.size(); i++) check("t6_spacing", lc[i] - lc[i-1], 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
